// File: rtl/noc_arb_pkg.sv
// Shared NoC arbitration definitions: port indices, address width and arbiter states.
package noc_arb_pkg;

  localparam int PORT_N     = 0;
  localparam int PORT_S     = 1;
  localparam int PORT_W     = 2;
  localparam int PORT_E     = 3;
  localparam int PORT_L     = 4;
  localparam int NOC_ADDR_W = 3;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Index width that stays legal for a single-input arbiter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_port_arbiter_if.sv
// Request/grant bundle between the input ports and one output-port arbiter.
// With RR_ARB_PERF_CNT_EN defined the bundle also carries the packet counters and their clear.
interface rr_port_arbiter_if
  import noc_arb_pkg::*;
#(
  parameter int NUM_IN = 5,
  parameter int ADDR_W = NOC_ADDR_W,
  parameter int CNT_W  = 16
);
  localparam int IDX_W = idx_width(NUM_IN);

  logic [NUM_IN-1:0]        req_valid_i;
  logic [NUM_IN*ADDR_W-1:0] nexthop_addr_i;
  logic [NUM_IN-1:0]        tail_i;
  logic                     out_ready_i;
  logic [NUM_IN-1:0]        grant_o;
  logic [IDX_W-1:0]         grant_idx_o;
  logic                     grant_valid_o;
  logic                     xfer_o;
`ifdef RR_ARB_PERF_CNT_EN
  logic [NUM_IN*CNT_W-1:0]  grant_cnt_o;
  logic                     cnt_clr_i;

  modport master (
    output req_valid_i, nexthop_addr_i, tail_i, out_ready_i, cnt_clr_i,
    input  grant_o, grant_idx_o, grant_valid_o, xfer_o, grant_cnt_o
  );
  modport slave (
    input  req_valid_i, nexthop_addr_i, tail_i, out_ready_i, cnt_clr_i,
    output grant_o, grant_idx_o, grant_valid_o, xfer_o, grant_cnt_o
  );
`else
  modport master (
    output req_valid_i, nexthop_addr_i, tail_i, out_ready_i,
    input  grant_o, grant_idx_o, grant_valid_o, xfer_o
  );
  modport slave (
    input  req_valid_i, nexthop_addr_i, tail_i, out_ready_i,
    output grant_o, grant_idx_o, grant_valid_o, xfer_o
  );
`endif

endinterface

// File: rtl/rr_port_arbiter_rr_pick.sv
// Circular priority pick: first set request at or after ptr, wrapping NUM_IN-1 -> 0.
module rr_pick
  import noc_arb_pkg::*;
#(
  parameter int NUM_IN = 5,
  parameter int IDX_W  = idx_width(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] onehot,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      int j;
      // Explicit wrap so non-power-of-two NUM_IN works.
      j = int'(ptr) + k;
      if (j >= NUM_IN) j = j - NUM_IN;
      if (!found && req[j]) begin
        found     = 1'b1;
        idx       = IDX_W'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_port_arbiter.sv
// Round-robin wormhole arbiter for one router output port.
// Optional per-input packet counters are enabled with RR_ARB_PERF_CNT_EN.
module rr_port_arbiter
  import noc_arb_pkg::*;
#(
  parameter int                NUM_IN       = 5,
  parameter int                ADDR_W       = NOC_ADDR_W,
  parameter int                PORT_ID      = PORT_L,
  parameter logic [NUM_IN-1:0] EXCLUDE_MASK = NUM_IN'(5'b10000),
  parameter int                CNT_W        = 16
) (
  input logic         clk,
  input logic         reset,
  rr_port_arbiter_if.slave bus
);
  localparam int         IDX_W     = idx_width(NUM_IN);
  localparam logic [0:0] ST_IDLE   = ARB_IDLE;
  localparam logic [0:0] ST_LOCKED = ARB_LOCKED;

  logic [0:0]        state;
  logic [IDX_W-1:0]  ptr;
  logic [NUM_IN-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid;
  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              xfer;
  logic              tail_xfer;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      req[i] = bus.req_valid_i[i]
             & (bus.nexthop_addr_i[i*ADDR_W +: ADDR_W] == ADDR_W'(PORT_ID))
             & ~EXCLUDE_MASK[i];
    end
  end

  rr_pick #(.NUM_IN(NUM_IN), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // Route is not rechecked while locked: body flits carry no next-hop.
  assign xfer      = (state == ST_LOCKED) & bus.req_valid_i[grant_idx] & bus.out_ready_i;
  assign tail_xfer = xfer & bus.tail_i[grant_idx];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (pick_found) begin
        state       <= ST_LOCKED;
        grant       <= pick_oh;
        grant_idx   <= pick_idx;
        grant_valid <= 1'b1;
      end
    end else if (tail_xfer) begin
      // grant_idx is kept so the crossbar select does not glitch between packets.
      state       <= ST_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      ptr         <= (grant_idx == IDX_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign bus.grant_o       = grant;
  assign bus.grant_idx_o   = grant_idx;
  assign bus.grant_valid_o = grant_valid;
  assign bus.xfer_o        = xfer;

`ifdef RR_ARB_PERF_CNT_EN
  logic [CNT_W-1:0] cnt [NUM_IN];

  // NOTE: the counter array is only NUM_IN registers, so it is reset like any other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
    end else if (bus.cnt_clr_i) begin
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (tail_xfer && grant_idx == IDX_W'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt_out
    assign bus.grant_cnt_o[g*CNT_W +: CNT_W] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed bench for rr_port_arbiter with a per-cycle packet-level reference model.
module tb_rr_port_arbiter;
  localparam int NUM_IN  = 5;
  localparam int ADDR_W  = 3;
  localparam int PORT_ID = 4;
  localparam int CNT_W   = 16;
  localparam logic [NUM_IN-1:0] EXCL = 5'b10000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  rr_port_arbiter_if #(.NUM_IN(NUM_IN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  rr_port_arbiter #(
    .NUM_IN(NUM_IN), .ADDR_W(ADDR_W), .PORT_ID(PORT_ID), .EXCLUDE_MASK(EXCL), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which input owns the port, and where the next search starts.
  bit m_locked;
  int m_owner;
  int m_ptr;

  function automatic bit wants(input int i);
    return bus.req_valid_i[i] && (int'(bus.nexthop_addr_i[i*ADDR_W +: ADDR_W]) == PORT_ID) && !EXCL[i];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_locked = 0;
      m_owner  = 0;
      m_ptr    = 0;
    end else if (!m_locked) begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (!m_locked && wants((m_ptr + k) % NUM_IN)) begin
          m_locked = 1;
          m_owner  = (m_ptr + k) % NUM_IN;
        end
      end
    end else if (bus.req_valid_i[m_owner] && bus.out_ready_i && bus.tail_i[m_owner]) begin
      m_locked = 0;
      m_ptr    = (m_owner + 1) % NUM_IN;
    end
  end

  always @(negedge clk) begin
    logic [NUM_IN-1:0] exp_grant;
    exp_grant = m_locked ? NUM_IN'(1 << m_owner) : '0;
    check("model_grant", 64'(bus.grant_o), 64'(exp_grant));
    check("model_valid", 64'(bus.grant_valid_o), 64'(m_locked));
    check("model_idx", 64'(bus.grant_idx_o), 64'(m_owner));
    check("model_xfer", 64'(bus.xfer_o),
          64'(m_locked && bus.req_valid_i[m_owner] && bus.out_ready_i));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic v, input int addr, input logic t);
    bus.req_valid_i[i]                   = v;
    bus.nexthop_addr_i[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    bus.tail_i[i]                        = t;
  endtask

  task automatic clear_in();
    bus.req_valid_i    = '0;
    bus.nexthop_addr_i = '0;
    bus.tail_i         = '0;
    bus.out_ready_i    = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_in();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  int fair_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
`ifdef RR_ARB_PERF_CNT_EN
    bus.cnt_clr_i = 1'b0;
`endif
    // Reset held while a request is active.
    clear_in();
    set_in(0, 1'b1, 4, 1'b1);
    tick();
    tick();
    #1;
    check("rst_grant", 64'(bus.grant_o), 64'h0);
    check("rst_valid", 64'(bus.grant_valid_o), 64'h0);
    check("rst_idx", 64'(bus.grant_idx_o), 64'h0);
    check("rst_xfer", 64'(bus.xfer_o), 64'h0);
    clear_in();
    reset = 1'b1;

    // Single-flit packet from input 1, then ptr=2 makes input 3 beat input 0.
    tick();
    set_in(1, 1'b1, 4, 1'b1);
    tick();
    #1;
    check("single_grant", 64'(bus.grant_o), 64'b00010);
    check("single_idx", 64'(bus.grant_idx_o), 64'd1);
    check("single_xfer", 64'(bus.xfer_o), 64'd1);
    tick();
    set_in(1, 1'b0, 4, 1'b0);
    #1;
    check("single_release", 64'(bus.grant_o), 64'h0);
    check("single_idx_kept", 64'(bus.grant_idx_o), 64'd1);
    set_in(0, 1'b1, 4, 1'b1);
    set_in(3, 1'b1, 4, 1'b1);
    tick();
    #1;
    check("ptr_after_1", 64'(bus.grant_idx_o), 64'd3);

    // Fairness: inputs 0..3 always requesting single-flit packets.
    do_reset();
    for (int i = 0; i < 4; i++) set_in(i, 1'b1, 4, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      #1;
      if (k % 2 == 0) begin
        check("fair_idx", 64'(bus.grant_idx_o), 64'(fair_seq[k/2]));
        check("fair_valid", 64'(bus.grant_valid_o), 64'd1);
      end else begin
        check("fair_gap", 64'(bus.grant_valid_o), 64'd0);
      end
    end

    // Wormhole hold: 3-flit packet from input 2 with a stall, input 0 waiting.
    do_reset();
    set_in(2, 1'b1, 4, 1'b0);
    tick();
    set_in(0, 1'b1, 4, 1'b1);
    #1;
    check("worm_head", 64'(bus.grant_o), 64'b00100);
    tick();
    bus.out_ready_i = 1'b0;
    #1;
    check("worm_stall", 64'(bus.grant_o), 64'b00100);
    check("worm_stall_xfer", 64'(bus.xfer_o), 64'd0);
    tick();
    bus.out_ready_i = 1'b1;
    #1;
    check("worm_body", 64'(bus.grant_o), 64'b00100);
    tick();
    set_in(2, 1'b1, 4, 1'b1);
    #1;
    check("worm_tail", 64'(bus.grant_o), 64'b00100);
    tick();
    set_in(2, 1'b0, 4, 1'b0);
    #1;
    check("worm_gap", 64'(bus.grant_valid_o), 64'd0);
    tick();
    #1;
    check("worm_next", 64'(bus.grant_o), 64'b00001);

    // Decode/exclusion: wrong address on input 3, excluded input 4.
    do_reset();
    set_in(3, 1'b1, 2, 1'b1);
    set_in(4, 1'b1, 4, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      check("excl_valid", 64'(bus.grant_valid_o), 64'd0);
    end

    // Mid-packet asynchronous reset.
    do_reset();
    set_in(1, 1'b1, 4, 1'b0);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("midrst_grant", 64'(bus.grant_o), 64'h0);
    check("midrst_valid", 64'(bus.grant_valid_o), 64'h0);
    check("midrst_idx", 64'(bus.grant_idx_o), 64'h0);
    check("midrst_xfer", 64'(bus.xfer_o), 64'h0);
    set_in(0, 1'b1, 4, 1'b1);
    #2;
    reset = 1'b1;
    tick();
    #1;
    check("midrst_after", 64'(bus.grant_o), 64'b00001);

`ifdef RR_ARB_PERF_CNT_EN
    // Three completed packets from input 2, then a clear pulse.
    do_reset();
    set_in(2, 1'b1, 4, 1'b1);
    repeat (6) tick();
    set_in(2, 1'b0, 4, 1'b0);
    #1;
    check("cnt_three", 64'(bus.grant_cnt_o[2*CNT_W +: CNT_W]), 64'd3);
    bus.cnt_clr_i = 1'b1;
    tick();
    bus.cnt_clr_i = 1'b0;
    #1;
    check("cnt_cleared", 64'(bus.grant_cnt_o[2*CNT_W +: CNT_W]), 64'd0);
`endif

    do_reset();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_port_arbiter.md
Name: rr_port_arbiter

Overview:
- Parametrised round-robin arbiter for one router output port.
- Decodes each input's next-hop address against PORT_ID and selects one requester with a rotating pointer.
- Holds the grant for a whole wormhole packet, head flit through tail flit, and drives the crossbar select.
- One instance per output port (N, S, W, E, L); generalises the fixed 4-input local-port processor.

Parameters:
- NUM_IN, 5, number of input ports (index 0=N, 1=S, 2=W, 3=E, 4=L).
- ADDR_W, 3, width of each next-hop address.
- PORT_ID, 4, address value this output port serves.
- EXCLUDE_MASK, 5'b10000, inputs that can never request this port (no U-turn).
- CNT_W, 16, grant counter width; used only with RR_ARB_PERF_CNT_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid_i  in  NUM_IN  flit valid per input.
- nexthop_addr_i  in  NUM_IN*ADDR_W  input i at [i*ADDR_W +: ADDR_W].
- tail_i  in  NUM_IN  current flit is the packet tail (a single-flit packet has tail=1).
- out_ready_i  in  1  downstream can accept a flit this cycle.
- grant_o  out  NUM_IN  registered one-hot grant.
- grant_idx_o  out  $clog2(NUM_IN)  crossbar select, registered.
- grant_valid_o  out  1  a grant is held.
- xfer_o  out  1  flit moves this cycle (combinational).
- grant_cnt_o  out  NUM_IN*CNT_W  present only with RR_ARB_PERF_CNT_EN.
- cnt_clr_i  in  1  present only with RR_ARB_PERF_CNT_EN.

Behaviour:
- Request decode: req[i] = req_valid_i[i] & (nexthop_i == PORT_ID) & ~EXCLUDE_MASK[i].
- Reset (reset=0, asynchronous): grant_o=0, grant_idx_o=0, grant_valid_o=0, ptr=0, state=IDLE, counters=0.
- Reset asserted mid-packet aborts the grant immediately; nothing is retained.
- State IDLE:
  - If req != 0, pick the first i with req[i] searching circularly from ptr (ptr, ptr+1, ..., wrapping NUM_IN-1 -> 0).
  - Register the pick into grant_o, grant_idx_o and grant_valid_o=1, then go to LOCKED.
  - Latency: request seen at cycle t gives grant at t+1.
  - If req == 0, stay in IDLE with outputs 0.
- State LOCKED (g = grant_idx_o):
  - xfer_o = req_valid_i[g] & out_ready_i. Next-hop is not rechecked while locked; body flits carry no route.
  - Grant is held through stalls (out_ready_i=0) and bubbles (req_valid_i[g]=0).
  - On xfer with tail_i[g]=1: ptr <= (g==NUM_IN-1) ? 0 : g+1. Next cycle state=IDLE and grant_o/grant_valid_o=0; grant_idx_o keeps its value.
  - There is exactly one idle cycle between consecutive packets.
- xfer_o=0 whenever state is IDLE.
- ptr changes only on a tail transfer. A requester that drops out while the grant is only pending does not exist, because the grant is registered.
- NUM_IN need not be a power of two; wrap is explicit.

Optional Feature:
- Macro: RR_ARB_PERF_CNT_EN.
- Defined:
  - Per-input CNT_W-bit counters count packets completed (tail xfer).
  - Counters saturate at all-ones.
  - cnt_clr_i=1 synchronously zeroes all counters; clear wins over a same-cycle increment.
  - Counters are exposed on grant_cnt_o.
- Undefined: counters, grant_cnt_o and cnt_clr_i do not exist; arbitration behaviour is identical.

Decomposition:
- Package noc_arb_pkg:
  - Port index constants PORT_N=0, PORT_S=1, PORT_W=2, PORT_E=3, PORT_L=4.
  - NOC_ADDR_W=3.
  - Enum arb_state_t {ARB_IDLE, ARB_LOCKED}.
- Sub-module rr_pick: combinational circular priority pick.
  - Inputs: req vector, ptr.
  - Outputs: one-hot, index, found.
  - Parameter: NUM_IN.

Test Plan (NUM_IN=5, PORT_ID=4, EXCLUDE_MASK=5'b10000):
- Reset: drive reset=0 with requests active -> grant_o=0, grant_valid_o=0, grant_idx_o=0, xfer_o=0.
- Single flit: input 1 valid, addr=4, tail=1, out_ready_i=1 at t -> grant_o=5'b00010 and grant_idx_o=1 at t+1; xfer_o=1; grant_o=0 at t+2; ptr=2.
- Fairness: inputs 0..3 request single-flit packets continuously, out_ready_i=1 -> grant idx sequence 0,1,2,3,0, one grant every 2 cycles.
- Wormhole hold: input 2 sends a 3-flit packet with out_ready_i=0 for the middle cycle while input 0 also requests -> grant stays 5'b00100 for 4 cycles; input 0 is granted only after the tail xfer of input 2.
- Decode/exclusion: input 3 addr=2, input 4 addr=4, both valid -> grant_valid_o stays 0.
- Mid-packet reset: drop reset to 0 during input 1's body flit -> outputs 0 without a clock edge; after release, input 0 requesting wins (ptr=0).
- (RR_ARB_PERF_CNT_EN) 3 completed packets from input 2, then cnt_clr_i pulse -> grant_cnt_o field 2 reads 3, then 0.
